// File: rtl/hidden_layer_seq.sv
// Time-multiplexed hidden layer: N_HID neurons over N_IN signed fixed-point inputs,
// evaluated one product per cycle on a single shared multiply-accumulate unit.
module hidden_layer_seq #(
  parameter int WIDTH = 20,
  parameter int FRAC  = 12,
  parameter int N_IN  = 2,
  parameter int N_HID = 4,
  localparam int NP   = N_HID*N_IN + N_HID,
  localparam int AW   = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*WIDTH-1:0]    x_flat,
  input  logic                     act_relu,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic [WIDTH-1:0]         w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_HID*WIDTH-1:0]   a_flat,
  output logic                     busy
);

  localparam int NW   = N_HID*N_IN;
  localparam int ACCW = 2*WIDTH + $clog2(N_IN+1);
  localparam int SW   = ACCW + 1;
  localparam int IW   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW   = (N_HID > 1) ? $clog2(N_HID) : 1;

  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

  state_t state_q, state_d;

  // Weights occupy [0, NW), biases [NW, NP) of one flat parameter store.
  logic signed [WIDTH-1:0] p_mem [NP];
  logic signed [WIDTH-1:0] x_r   [N_IN];
  logic signed [WIDTH-1:0] a_r   [N_HID];
  logic                    relu_r;
  logic signed [ACCW-1:0]  acc;
  logic [IW-1:0]           i_cnt;
  logic [JW-1:0]           j_cnt;

  logic                    last_i, last_j;
  logic [AW-1:0]           w_idx, b_idx;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [SW-1:0]    sum, shifted;
  logic signed [WIDTH-1:0] s_sat, s_act;

  // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = MAC;
      end
      MAC:  if (last_i) state_d = FIN;
      FIN:  state_d = last_j ? DONE : MAC;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Shared MAC datapath and the rounding/saturation/activation of one neuron.
  always_comb begin
    last_i  = (i_cnt == IW'(N_IN-1));
    last_j  = (j_cnt == JW'(N_HID-1));
    w_idx   = AW'(int'(j_cnt) * N_IN + int'(i_cnt));
    b_idx   = AW'(NW + int'(j_cnt));
    prod    = p_mem[w_idx] * x_r[i_cnt];
    sum     = SW'(acc) + (SW'(p_mem[b_idx]) <<< FRAC);
    shifted = sum >>> FRAC;
    // In range only when all bits above the result sign agree with it.
    if (shifted[SW-1:WIDTH-1] == {(SW-WIDTH+1){shifted[SW-1]}})
      s_sat = shifted[WIDTH-1:0];
    else if (shifted[SW-1])
      s_sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      s_sat = {1'b0, {(WIDTH-1){1'b1}}};
    s_act = (relu_r && s_sat[WIDTH-1]) ? '0 : s_sat;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      i_cnt  <= '0;
      j_cnt  <= '0;
      relu_r <= 1'b0;
      for (int i = 0; i < N_IN; i++)  x_r[i] <= '0;
      for (int j = 0; j < N_HID; j++) a_r[j] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) x_r[i] <= x_flat[i*WIDTH +: WIDTH];
            relu_r <= act_relu;
            acc    <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          if (!last_i) i_cnt <= i_cnt + 1'b1;
        end
        FIN: begin
          a_r[j_cnt] <= s_act;
          acc        <= '0;
          i_cnt      <= '0;
          if (!last_j) j_cnt <= j_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the parameter store is reset explicitly, so it must stay in flops rather than
  // a RAM macro; a reset mid-run therefore leaves every weight and bias at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NP; k++) p_mem[k] <= '0;
    end else if (w_we && !busy && ({1'b0, w_addr} < (AW+1)'(NP))) begin
      p_mem[w_addr] <= w_data;
    end
  end

  always_comb begin
    a_flat = '0;
    for (int j = 0; j < N_HID; j++) a_flat[j*WIDTH +: WIDTH] = a_r[j];
  end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Self-checking bench for hidden_layer_seq: directed transactions compared every
// output-valid cycle against an integer model of the layer, plus literal pins.
module tb_hidden_layer_seq;
  localparam int WIDTH = 20;
  localparam int FRAC  = 12;
  localparam int N_IN  = 2;
  localparam int N_HID = 4;
  localparam int AW    = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [N_IN*WIDTH-1:0]  x_flat = '0;
  logic                   act_relu = 1'b0;
  logic                   w_we = 1'b0;
  logic [AW-1:0]          w_addr = '0;
  logic [WIDTH-1:0]       w_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [N_HID*WIDTH-1:0] a_flat;
  logic                   busy;

  always #5 clk = ~clk;

  hidden_layer_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .N_IN(N_IN), .N_HID(N_HID)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_flat(x_flat),
    .act_relu(act_relu), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .a_flat(a_flat), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  longint           w_m [N_HID][N_IN];
  longint           b_m [N_HID];
  logic [WIDTH-1:0] exp_a [N_HID];
  bit               chk_en = 1'b0;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  function automatic longint sx(input logic [WIDTH-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic m_clear();
    for (int j = 0; j < N_HID; j++) begin
      b_m[j] = 0;
      for (int i = 0; i < N_IN; i++) w_m[j][i] = 0;
    end
  endtask

  task automatic m_write(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    int k;
    k = int'(addr);
    if (k < N_HID*N_IN) w_m[k / N_IN][k % N_IN] = sx(data);
    else if (k < N_HID*N_IN + N_HID) b_m[k - N_HID*N_IN] = sx(data);
  endtask

  // Each neuron: floor((sum w*x + b*2^FRAC) / 2^FRAC), clamp to WIDTH bits, optional ReLU.
  task automatic m_eval(input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] x1, input bit relu);
    longint xs [N_IN];
    longint s, hi, lo;
    hi = (longint'(1) <<< (WIDTH-1)) - 1;
    lo = -(longint'(1) <<< (WIDTH-1));
    xs[0] = sx(x0);
    xs[1] = sx(x1);
    for (int j = 0; j < N_HID; j++) begin
      s = b_m[j] * (longint'(1) <<< FRAC);
      for (int i = 0; i < N_IN; i++) s += w_m[j][i] * xs[i];
      s = s >>> FRAC;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      if (relu && s < 0) s = 0;
      exp_a[j] = s[WIDTH-1:0];
    end
  endtask

  // All bench drives happen just after a falling edge.
  task automatic wr(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    w_we = 1'b1; w_addr = addr; w_data = data;
    m_write(addr, data);
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic run(input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] x1, input bit relu,
                     input int hold, input bit noise, input bit hs_we,
                     input logic [AW-1:0] hs_addr, input logic [WIDTH-1:0] hs_data);
    int lat;
    check("hs_in_ready", {79'd0, in_ready}, 80'd1);
    in_valid = 1'b1; x_flat = {x1, x0}; act_relu = relu;
    if (hs_we) begin
      w_we = 1'b1; w_addr = hs_addr; w_data = hs_data;
      m_write(hs_addr, hs_data);
    end
    m_eval(x0, x1, relu);
    chk_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; w_we = 1'b0; act_relu = !relu; x_flat = {x0 ^ 20'h5A5A5, x1 ^ 20'h3C3C3};
    check("busy_after_hs", {79'd0, busy}, 80'd1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      in_valid = noise && (lat == 2);
      w_we     = noise && (lat == 2);
      w_addr   = '0;
      w_data   = 20'h12345;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0; w_we = 1'b0;
    check("latency", 80'(lat), 80'd13);
    for (int c = 0; c < hold; c++) begin
      check("hold_in_ready", {79'd0, in_ready}, 80'd0);
      check("hold_out_valid", {79'd0, out_valid}, 80'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_out_valid", {79'd0, out_valid}, 80'd0);
    check("back_idle", {78'd0, in_ready, busy}, 80'd2);
  endtask

  // Per-cycle compare against the model while a result is presented.
  always @(negedge clk) begin
    check("ready_vs_busy", {79'd0, in_ready}, {79'd0, !busy});
    if (out_valid) begin
      check("valid_busy", {79'd0, busy}, 80'd1);
      if (chk_en)
        for (int j = 0; j < N_HID; j++)
          check("cmp_a", 80'(a_flat[j*WIDTH +: WIDTH]), 80'(exp_a[j]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] rx0, rx1;
    m_clear();
    repeat (2) @(negedge clk);
    check("rst_in_ready", {79'd0, in_ready}, 80'd1);
    check("rst_out_valid", {79'd0, out_valid}, 80'd0);
    check("rst_busy", {79'd0, busy}, 80'd0);
    check("rst_a_flat", a_flat, 80'd0);
    rst = 1'b0;

    // Linear case with a busy-time write and a stray in_valid during MAC.
    wr(4'd0, 20'h01000); wr(4'd1, 20'h01000);
    wr(4'd2, 20'h01000); wr(4'd3, 20'hFF000);
    wr(4'd4, 20'hFF000); wr(4'd5, 20'h00000);
    wr(4'd6, 20'h00000); wr(4'd7, 20'h00000);
    wr(4'd11, 20'h00800);
    wr(4'd12, 20'h7FFFF);
    wr(4'd15, 20'h7FFFF);
    run(20'h04200, 20'h04100, 1'b0, 10, 1'b1, 1'b0, '0, '0);
    check("lin_a0", 80'(a_flat[19:0]),  80'h08300);
    check("lin_a1", 80'(a_flat[39:20]), 80'h00100);
    check("lin_a2", 80'(a_flat[59:40]), 80'hFBE00);
    check("lin_a3", 80'(a_flat[79:60]), 80'h00800);

    // ReLU case, same stimulus.
    run(20'h04200, 20'h04100, 1'b1, 2, 1'b0, 1'b0, '0, '0);
    check("relu_a0", 80'(a_flat[19:0]),  80'h08300);
    check("relu_a1", 80'(a_flat[39:20]), 80'h00100);
    check("relu_a2", 80'(a_flat[59:40]), 80'h00000);
    check("relu_a3", 80'(a_flat[79:60]), 80'h00800);

    // Positive saturation; b0 = 1.0 written in the handshake cycle.
    wr(4'd6, 20'h7FFFF); wr(4'd7, 20'h7FFFF);
    run(20'h04200, 20'h04100, 1'b0, 0, 1'b0, 1'b1, 4'd8, 20'h01000);
    check("sat_hi_a3", 80'(a_flat[79:60]), 80'h7FFFF);
    check("hs_write_a0", 80'(a_flat[19:0]), 80'h09300);

    // Negative saturation, then clipped by ReLU.
    wr(4'd6, 20'h80000); wr(4'd7, 20'h80000);
    run(20'h04200, 20'h04100, 1'b0, 1, 1'b0, 1'b0, '0, '0);
    check("sat_lo_a3", 80'(a_flat[79:60]), 80'h80000);
    run(20'h04200, 20'h04100, 1'b1, 0, 1'b1, 1'b0, '0, '0);
    check("sat_relu_a3", 80'(a_flat[79:60]), 80'h00000);

    // A few transactions with arbitrary parameters, checked by the model only.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 12; k++) wr(AW'(k), 20'($urandom));
      rx0 = 20'($urandom);
      rx1 = 20'($urandom);
      run(rx0, rx1, r[0], 1, 1'b1, 1'b0, '0, '0);
    end

    // Reset partway through a computation.
    in_valid = 1'b1; x_flat = {20'h04100, 20'h04200}; act_relu = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", {79'd0, out_valid}, 80'd0);
    check("mid_rst_idle", {78'd0, in_ready, busy}, 80'd2);
    check("mid_rst_a_flat", a_flat, 80'd0);
    rst = 1'b0;
    m_clear();
    run(20'h04200, 20'h04100, 1'b0, 0, 1'b0, 1'b0, '0, '0);
    check("post_rst_lin", a_flat, 80'd0);
    run(20'h7FFFF, 20'h80000, 1'b1, 0, 1'b0, 1'b0, '0, '0);
    check("post_rst_relu", a_flat, 80'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
